// File: rtl/shield_read_resp_gen_if.sv
// Request and AXI R-channel bundle for the shield read-response generator.
// The master side drives requests and rready; the slave side (the generator) drives R beats.
interface shield_read_resp_gen_if #(
    parameter int unsigned ID_W   = 6,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned LINE_W = 512,
    parameter int unsigned OFF_W  = 6
);
    logic [LINE_W-1:0] cache_line;
    logic [ID_W-1:0]   req_id;
    logic              req_err;
    logic [7:0]        burst_count;
    logic [OFF_W-1:0]  burst_start_offset;
    logic              burst_last;
    logic              input_val;
    logic              input_rdy;

    logic [ID_W-1:0]   s_axi_rid;
    logic [DATA_W-1:0] s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rlast;
    logic              s_axi_rvalid;
    logic              s_axi_rready;

    modport master (
        output cache_line, req_id, req_err, burst_count, burst_start_offset,
               burst_last, input_val, s_axi_rready,
        input  input_rdy, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid
    );

    modport slave (
        input  cache_line, req_id, req_err, burst_count, burst_start_offset,
               burst_last, input_val, s_axi_rready,
        output input_rdy, s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid
    );
endinterface

// File: rtl/shield_read_resp_gen.sv
// Slices one verified cache line per request into AXI R beats (with ID, SLVERR and rlast)
// and queues them in a first-word-fall-through FIFO toward the CL read master.
module shield_read_resp_gen #(
    parameter int unsigned CL_ID_WIDTH   = 6,
    parameter int unsigned CL_DATA_WIDTH = 64,
    parameter int unsigned LINE_WIDTH    = 512,
    parameter int unsigned OFFSET_WIDTH  = 6,
    parameter int unsigned FIFO_DEPTH    = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    shield_read_resp_gen_if.slave       bus,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int unsigned BEATS  = LINE_WIDTH / CL_DATA_WIDTH;
    localparam int unsigned BIDX_W = $clog2(BEATS);
    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = AW + 1;

    typedef enum logic [0:0] {IDLE = 1'b0, SEND = 1'b1} state_t;

    typedef struct packed {
        logic [CL_DATA_WIDTH-1:0] data;
        logic [CL_ID_WIDTH-1:0]   id;
        logic [1:0]               resp;
        logic                     last;
    } r_beat_t;

    state_t state, state_n;

    logic                     accept;
    logic                     push;
    logic                     pop;
    logic                     full;
    logic                     empty;
    logic                     rdy;

    logic [LINE_WIDTH-1:0]    line_r;
    logic [CL_ID_WIDTH-1:0]   id_r;
    logic                     err_r;
    logic                     last_r;
    logic [BIDX_W-1:0]        idx;
    logic [BIDX_W-1:0]        idx_inc;
    logic [7:0]               rem;

    logic [CL_DATA_WIDTH-1:0] line_beats [BEATS];
    r_beat_t                  push_beat;
    r_beat_t                  head;
    r_beat_t                  mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [CNT_W-1:0]         count;

    // Only the beat-select bits of the byte offset matter.
    logic                     unused_offset_bits;
    assign unused_offset_bits = ^bus.burst_start_offset[OFFSET_WIDTH-BIDX_W-1:0];

    for (genvar g = 0; g < BEATS; g++) begin : g_split
        assign line_beats[g] = line_r[g*CL_DATA_WIDTH +: CL_DATA_WIDTH];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (bus.input_val && (bus.burst_count != 8'd0)) state_n = SEND;
            SEND: if (push && (rem == 8'd1))                      state_n = IDLE;
            default:                                              state_n = IDLE;
        endcase
    end

    // FSM outputs; push is held off while full even if a pop happens the same cycle
    always_comb begin
        rdy    = 1'b0;
        accept = 1'b0;
        push   = 1'b0;
        case (state)
            IDLE: begin
                rdy    = 1'b1;
                accept = bus.input_val;
            end
            SEND: push = (rem != 8'd0) && !full;
            default: ;
        endcase
    end

    // Request capture and beat walking; idx wraps modulo BEATS
    assign idx_inc = (idx == BIDX_W'(BEATS - 1)) ? '0 : idx + BIDX_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_r <= '0;
            id_r   <= '0;
            err_r  <= 1'b0;
            last_r <= 1'b0;
            idx    <= '0;
            rem    <= 8'd0;
        end else if (accept) begin
            line_r <= bus.cache_line;
            id_r   <= bus.req_id;
            err_r  <= bus.req_err;
            last_r <= bus.burst_last;
            idx    <= bus.burst_start_offset[OFFSET_WIDTH-1 -: BIDX_W];
            rem    <= bus.burst_count;
        end else if (push) begin
            idx <= idx_inc;
            rem <= rem - 8'd1;
        end
    end

    always_comb begin
        push_beat.data = line_beats[idx];
        push_beat.id   = id_r;
        push_beat.resp = err_r ? 2'b10 : 2'b00;
        push_beat.last = last_r && (rem == 8'd1);
    end

    // Output FIFO
    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);
    assign pop   = !empty && bus.s_axi_rready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_beat;
    end

    assign head = mem[rd_ptr];

    // Head is held until handshake; payload forced to zero while empty
    assign bus.s_axi_rvalid = !empty;
    assign bus.s_axi_rdata  = empty ? '0   : head.data;
    assign bus.s_axi_rid    = empty ? '0   : head.id;
    assign bus.s_axi_rresp  = empty ? 2'b00 : head.resp;
    assign bus.s_axi_rlast  = empty ? 1'b0 : head.last;
    assign bus.input_rdy    = rdy;

    assign busy       = (state != IDLE) || !empty;
    assign fifo_count = count;
endmodule

// File: tb/tb_shield_read_resp_gen.sv
// Randomised scoreboard bench for shield_read_resp_gen: requests push expected beats,
// a negedge monitor pops and compares every R handshake.
module tb_shield_read_resp_gen;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned NBEAT = 8;

    typedef struct {
        logic [63:0] data;
        logic [5:0]  id;
        logic [1:0]  resp;
        logic        last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       busy;
    logic [2:0] fifo_count;

    int tests_run = 0;
    int failures  = 0;
    int rready_mode = 1;   // 0 random, 1 always on, 2 always off
    bit mon_en = 1'b0;
    exp_t sb[$];

    shield_read_resp_gen_if #(.ID_W(6), .DATA_W(64), .LINE_W(512), .OFF_W(6)) bus ();

    shield_read_resp_gen #(
        .CL_ID_WIDTH(6), .CL_DATA_WIDTH(64), .LINE_WIDTH(512),
        .OFFSET_WIDTH(6), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] rand_line();
        logic [511:0] l;
        for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    // rready driver, changed just after the active edge
    initial begin
        bus.s_axi_rready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (rready_mode)
                0:       bus.s_axi_rready = ($urandom_range(3) != 0);
                1:       bus.s_axi_rready = 1'b1;
                default: bus.s_axi_rready = 1'b0;
            endcase
        end
    end

    // Monitor: compares the presented beat with the scoreboard head, pops on handshake
    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            check("fifo_count_bound", 64'(fifo_count > 3'(DEPTH)), 64'd0);
            if (bus.s_axi_rvalid) begin
                if (sb.size() == 0) begin
                    check("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    check("rdata", bus.s_axi_rdata, sb[0].data);
                    check("rid",   64'(bus.s_axi_rid),   64'(sb[0].id));
                    check("rresp", 64'(bus.s_axi_rresp), 64'(sb[0].resp));
                    check("rlast", 64'(bus.s_axi_rlast), 64'(sb[0].last));
                    if (bus.s_axi_rready) void'(sb.pop_front());
                end
            end else begin
                check("empty_payload_zero",
                      64'(|{bus.s_axi_rdata, bus.s_axi_rid, bus.s_axi_rresp, bus.s_axi_rlast}), 64'd0);
            end
        end
    end

    // Reference: beat k of a request reads line beat (start+k) mod NBEAT
    task automatic send_req(input logic [511:0] line, input logic [5:0] id, input logic err,
                            input logic [7:0] cnt, input logic [5:0] off, input logic last);
        exp_t e;
        int   start;
        int   n;
        start = int'(off) / 8;
        for (int k = 0; k < int'(cnt); k++) begin
            int b;
            b      = (start + k) % NBEAT;
            e.data = line[b*64 +: 64];
            e.id   = id;
            e.resp = err ? 2'b10 : 2'b00;
            e.last = last && (k == int'(cnt) - 1);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.cache_line         = line;
        bus.req_id             = id;
        bus.req_err            = err;
        bus.burst_count        = cnt;
        bus.burst_start_offset = off;
        bus.burst_last         = last;
        bus.input_val          = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.input_rdy && n < 300);
        if (!bus.input_rdy) check("accept_timeout", 64'd1, 64'd0);
        @(posedge clk);
        #1;
        bus.input_val = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sb.size() != 0 || busy) && n < 1000);
        check({name, "_sb_empty"}, 64'(sb.size()), 64'd0);
        check({name, "_busy"}, 64'(busy), 64'd0);
        check({name, "_rdy"}, 64'(bus.input_rdy), 64'd1);
    endtask

    initial begin
        logic [511:0] l;
        int n;
        rst_n = 1'b0;
        bus.cache_line = '0; bus.req_id = '0; bus.req_err = 1'b0; bus.burst_count = '0;
        bus.burst_start_offset = '0; bus.burst_last = 1'b0; bus.input_val = 1'b0;
        #12;
        check("rst_rvalid", 64'(bus.s_axi_rvalid), 64'd0);
        check("rst_busy",   64'(busy), 64'd0);
        check("rst_count",  64'(fifo_count), 64'd0);
        check("rst_rdy",    64'(bus.input_rdy), 64'd1);
        check("rst_rdata",  bus.s_axi_rdata, 64'd0);
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Full line in order, latency T+2
        rready_mode = 1;
        send_req(rand_line(), 6'd5, 1'b0, 8'd8, 6'd0, 1'b1);
        @(negedge clk);
        check("lat_t1_rvalid", 64'(bus.s_axi_rvalid), 64'd0);
        @(negedge clk);
        check("lat_t2_rvalid", 64'(bus.s_axi_rvalid), 64'd1);
        drain("t1");

        // Wrap from beat 7
        send_req(rand_line(), 6'd9, 1'b0, 8'd3, 6'h38, 1'b1);
        drain("t2");

        // Backpressure: FIFO saturates, nothing lost
        rready_mode = 2;
        send_req(rand_line(), 6'd17, 1'b0, 8'd8, 6'd0, 1'b1);
        repeat (12) @(negedge clk);
        check("t3_full_count", 64'(fifo_count), 64'(DEPTH));
        check("t3_still_send", 64'(bus.input_rdy), 64'd0);
        rready_mode = 1;
        drain("t3");

        // SLVERR burst then OKAY tail
        send_req(rand_line(), 6'd3, 1'b1, 8'd2, 6'd8, 1'b0);
        send_req(rand_line(), 6'd3, 1'b0, 8'd1, 6'd0, 1'b1);
        drain("t4");

        // Zero-beat request
        send_req(rand_line(), 6'd7, 1'b0, 8'd0, 6'd16, 1'b1);
        @(negedge clk);
        check("t5_rdy", 64'(bus.input_rdy), 64'd1);
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_rvalid", 64'(bus.s_axi_rvalid), 64'd0);

        // Randomised traffic
        rready_mode = 0;
        for (int i = 0; i < 40; i++) begin
            l = rand_line();
            send_req(l, 6'($urandom), 1'($urandom), 8'($urandom_range(8)),
                     6'($urandom), 1'($urandom));
        end
        rready_mode = 1;
        drain("rand");

        // Reset in the middle of a burst
        rready_mode = 2;
        send_req(rand_line(), 6'd11, 1'b0, 8'd8, 6'd0, 1'b1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (fifo_count != 3'd3 && n < 50);
        check("t6_reached3", 64'(fifo_count), 64'd3);
        rst_n = 1'b0;
        #1;
        sb.delete();
        check("t6_rvalid_drop", 64'(bus.s_axi_rvalid), 64'd0);
        check("t6_count_rst", 64'(fifo_count), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("t6_count_after", 64'(fifo_count), 64'd0);
        check("t6_rdy_after", 64'(bus.input_rdy), 64'd1);
        check("t6_rvalid_after", 64'(bus.s_axi_rvalid), 64'd0);
        rready_mode = 1;
        send_req(rand_line(), 6'd12, 1'b0, 8'd4, 6'd40, 1'b1);
        drain("t6");

        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule
